// File: rtl/ehgu_fifo_arb_pkg.sv
// Shared types and helpers for the ehgu FIFO write-side arbiter.
// No logic of its own: state encoding and the credit counter width rule.
// Not in the data path, so it has no latency or backpressure of its own.
package ehgu_fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Counter must hold every value from 0 up to and including DEPTH.
  function automatic int crd_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ehgu_rr_pick.sv
// Rotating priority encoder: first set request at or after i_ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the pick.
module ehgu_rr_pick #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // Scan offsets 0..NREQ-1 from the pointer; the first hit wins.
  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_any && i_req[(int'(i_ptr) + k) % NREQ]) begin
        o_any = 1'b1;
        o_idx = IW'((int'(i_ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/ehgu_fifo_wr_arb.sv
// Round-robin, burst-limited arbiter and credit manager for the FIFO write port.
// Latency: grant one cycle after a request is seen idle; data one cycle after accept.
// Backpressure: req_ready is gated by arb_en and by a non-zero free-slot credit count.
module ehgu_fifo_wr_arb
  import ehgu_fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 128,
  parameter int MAX_BURST = 4,
  localparam int CW       = crd_width(DEPTH),
  localparam int GW       = $clog2(NREQ)
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  arb_en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  crd_ret,
  output logic                  fifo_en,
  output logic                  fifo_din_valid,
  output logic [WIDTH-1:0]      fifo_din,
  output logic [GW-1:0]         gnt_id,
  output logic [CW-1:0]         credits,
  output logic                  crd_err
);

  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t       r_state;
  logic [GW-1:0]    r_gnt_id;
  logic [GW-1:0]    r_rr_ptr;
  logic [BW-1:0]    r_beat_cnt;
  logic [CW-1:0]    r_credits;
  logic             r_crd_err;
  logic             r_fifo_en;
  logic             r_fifo_din_valid;
  logic [WIDTH-1:0] r_fifo_din;

  logic [GW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic             w_has_crd;
  logic             w_cur_vld;
  logic             w_xfer;
  logic [CW-1:0]    w_crd_eff;
  logic             w_crd_add;
  logic             w_crd_ovf;
  logic [CW-1:0]    w_crd_next;
  logic [BW-1:0]    w_beat_inc;
  logic             w_last_beat;
  logic             w_leave;
  logic [GW-1:0]    w_rr_next;
  logic [WIDTH-1:0] w_sel_dat;

  ehgu_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_has_crd = (r_credits != '0);
  assign w_cur_vld = req_valid[r_gnt_id];
  assign req_ready = ((r_state == GRANT) && arb_en && w_has_crd) ? (NREQ'(1) << r_gnt_id) : '0;
  assign w_xfer    = |(req_ready & req_valid);
  assign w_sel_dat = req_data[r_gnt_id*WIDTH +: WIDTH];

  // A return is only absorbed if the count after this cycle's consume is below DEPTH;
  // otherwise the read side returned a slot we never handed out.
  assign w_crd_eff  = r_credits - CW'(w_xfer);
  assign w_crd_add  = crd_ret && (w_crd_eff < CW'(DEPTH));
  assign w_crd_ovf  = crd_ret && !w_crd_add;
  assign w_crd_next = w_crd_eff + CW'(w_crd_add);

  assign w_beat_inc  = r_beat_cnt + BW'(1);
  assign w_last_beat = w_xfer && (w_beat_inc == BW'(MAX_BURST));
  assign w_leave     = w_last_beat || !w_cur_vld || !arb_en || (w_crd_next == '0);
  assign w_rr_next   = (r_gnt_id == GW'(NREQ - 1)) ? '0 : r_gnt_id + GW'(1);

  // Output staging toward the FIFO plus credit bookkeeping.
  always_ff @(posedge clk0) begin
    if (rst) begin
      r_fifo_en        <= 1'b0;
      r_fifo_din_valid <= 1'b0;
      r_fifo_din       <= '0;
      r_credits        <= CW'(DEPTH);
      r_crd_err        <= 1'b0;
    end else begin
      r_fifo_en        <= arb_en;
      r_fifo_din_valid <= w_xfer;
      if (w_xfer) begin
        r_fifo_din <= w_sel_dat;
      end
      r_credits <= w_crd_next;
      if (w_crd_ovf) begin
        r_crd_err <= 1'b1;
      end
    end
  end

  // Grant FSM: pick in IDLE, stream up to MAX_BURST beats in GRANT, then rotate.
  always_ff @(posedge clk0) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt_id   <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (arb_en && w_has_crd && w_pick_any) begin
            r_gnt_id   <= w_pick_idx;
            r_beat_cnt <= '0;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (w_xfer) begin
            r_beat_cnt <= w_beat_inc;
          end
          if (w_leave) begin
            r_rr_ptr <= w_rr_next;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fifo_en        = r_fifo_en;
  assign fifo_din_valid = r_fifo_din_valid;
  assign fifo_din       = r_fifo_din;
  assign gnt_id         = r_gnt_id;
  assign credits        = r_credits;
  assign crd_err        = r_crd_err;

endmodule

// File: tb/tb_ehgu_fifo_wr_arb.sv
// Self-checking bench for ehgu_fifo_wr_arb: directed table, hand sequences, random vs model.
// One call of cyc() is one clock cycle; inputs change 1ns after the rising edge.
// Registered outputs are compared 1ns after the edge, req_ready just before it.
module tb_ehgu_fifo_wr_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 128;
  localparam int MB    = 4;

  logic        clk0 = 1'b0;
  logic        rst;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        crd_ret;
  logic        fifo_en;
  logic        fifo_din_valid;
  logic [7:0]  fifo_din;
  logic [1:0]  gnt_id;
  logic [7:0]  credits;
  logic        crd_err;

  always #5 clk0 = ~clk0;

  ehgu_fifo_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clk0           (clk0),
    .rst            (rst),
    .arb_en         (arb_en),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .crd_ret        (crd_ret),
    .fifo_en        (fifo_en),
    .fifo_din_valid (fifo_din_valid),
    .fifo_din       (fifo_din),
    .gnt_id         (gnt_id),
    .credits        (credits),
    .crd_err        (crd_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: spec-level state kept as plain integers.
  bit       m_busy;
  int       m_owner;
  int       m_beats;
  int       m_next_first;
  int       m_cred;
  bit       m_err;
  bit       m_fen;
  bit       m_fv;
  int       m_fd;
  logic [3:0] obs_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_next_first = 0;
    m_cred = DEPTH; m_err = 0; m_fen = 0; m_fv = 0; m_fd = 0;
  endtask

  task automatic cyc(input bit r, input bit en, input logic [3:0] v, input logic [31:0] d, input bit cr);
    logic [3:0] erdy;
    bit x;
    int cold;
    bit found;
    rst = r; arb_en = en; req_valid = v; req_data = d; crd_ret = cr;
    #1;
    erdy = (m_busy && en && m_cred > 0) ? 4'(1 << m_owner) : 4'h0;
    obs_rdy = req_ready;
    chk("req_ready", req_ready, erdy);
    x = (erdy != 0) && v[m_owner];
    if (r) begin
      model_reset();
    end else begin
      m_fen = en;
      m_fv  = x;
      if (x) m_fd = int'(d[m_owner*8 +: 8]);
      cold = m_cred;
      if (x && !cr) m_cred = m_cred - 1;
      else if (!x && cr) begin
        if (m_cred == DEPTH) m_err = 1;
        else m_cred = m_cred + 1;
      end
      if (!m_busy) begin
        if (en && cold > 0 && v != 0) begin
          found = 0;
          for (int k = 0; k < NREQ; k++) begin
            if (!found && v[(m_next_first + k) % NREQ]) begin
              found = 1;
              m_owner = (m_next_first + k) % NREQ;
            end
          end
          m_beats = 0;
          m_busy = 1;
        end
      end else begin
        if (x) m_beats++;
        if ((x && m_beats == MB) || !v[m_owner] || !en || m_cred == 0) begin
          m_busy = 0;
          m_next_first = (m_owner + 1) % NREQ;
        end
      end
    end
    @(posedge clk0);
    #1;
    chk("fifo_en", fifo_en, m_fen);
    chk("fifo_din_valid", fifo_din_valid, m_fv);
    chk("fifo_din", fifo_din, m_fd);
    chk("credits", credits, m_cred);
    chk("crd_err", crd_err, m_err);
    chk("gnt_id", gnt_id, m_owner);
  endtask

  task automatic do_reset();
    cyc(1, 0, 4'h0, 32'h0, 0);
    cyc(1, 0, 4'h0, 32'h0, 0);
  endtask

  typedef struct {
    logic [3:0] vld;
    logic [7:0] dat;
    logic [3:0] rdy;
    logic       fv;
    logic [7:0] din;
    int         cred;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int cnt;
    int runs;
    int run_id;
    int run_len;
    bit run_on;
    int id;

    // Single requester 2, 10 beats: bursts 4,4,2 separated by one idle cycle.
    tbl[0]  = '{4'h4, 8'h00, 4'h0, 1'b0, 8'h00, 128};
    tbl[1]  = '{4'h4, 8'h10, 4'h4, 1'b1, 8'h10, 127};
    tbl[2]  = '{4'h4, 8'h11, 4'h4, 1'b1, 8'h11, 126};
    tbl[3]  = '{4'h4, 8'h12, 4'h4, 1'b1, 8'h12, 125};
    tbl[4]  = '{4'h4, 8'h13, 4'h4, 1'b1, 8'h13, 124};
    tbl[5]  = '{4'h4, 8'h00, 4'h0, 1'b0, 8'h13, 124};
    tbl[6]  = '{4'h4, 8'h14, 4'h4, 1'b1, 8'h14, 123};
    tbl[7]  = '{4'h4, 8'h15, 4'h4, 1'b1, 8'h15, 122};
    tbl[8]  = '{4'h4, 8'h16, 4'h4, 1'b1, 8'h16, 121};
    tbl[9]  = '{4'h4, 8'h17, 4'h4, 1'b1, 8'h17, 120};
    tbl[10] = '{4'h4, 8'h00, 4'h0, 1'b0, 8'h17, 120};
    tbl[11] = '{4'h4, 8'h18, 4'h4, 1'b1, 8'h18, 119};
    tbl[12] = '{4'h4, 8'h19, 4'h4, 1'b1, 8'h19, 118};
    tbl[13] = '{4'h0, 8'h00, 4'h4, 1'b0, 8'h19, 118};
    tbl[14] = '{4'h0, 8'h00, 4'h0, 1'b0, 8'h19, 118};

    rst = 1'b1; arb_en = 1'b0; req_valid = '0; req_data = '0; crd_ret = 1'b0;
    obs_rdy = '0;
    model_reset();
    repeat (2) @(posedge clk0);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_ready", req_ready, 4'h0);
    chk("rst_credits", credits, 8'd128);
    chk("rst_crd_err", crd_err, 1'b0);
    chk("rst_fifo_en", fifo_en, 1'b0);
    chk("rst_din_valid", fifo_din_valid, 1'b0);
    chk("rst_din", fifo_din, 8'h00);
    chk("rst_gnt_id", gnt_id, 2'd0);
    @(posedge clk0);
    #1;

    // Directed table.
    for (int i = 0; i < 15; i++) begin
      cyc(0, 1, tbl[i].vld, {8'hEE, tbl[i].dat, 8'h55, 8'hAA}, 0);
      chk("tbl_ready", obs_rdy, tbl[i].rdy);
      chk("tbl_din_valid", fifo_din_valid, tbl[i].fv);
      chk("tbl_din", fifo_din, tbl[i].din);
      chk("tbl_credits", credits, tbl[i].cred);
    end
    chk("tbl_gnt_id", gnt_id, 2'd2);

    // Fairness: all requesters valid, expect 0,1,2,3,... with 4 beats each.
    do_reset();
    runs = 0; run_on = 0; run_id = 0; run_len = 0;
    for (int c = 0; c < 60; c++) begin
      cyc(0, 1, 4'hF, $urandom, 0);
      if (obs_rdy != 0) begin
        id = 0;
        for (int b = 0; b < 4; b++) if (obs_rdy[b]) id = b;
        if (!run_on) begin
          run_on = 1; run_id = id; run_len = 1;
        end else begin
          run_len++;
        end
      end else if (run_on) begin
        chk("fair_order", run_id, runs % 4);
        chk("fair_len", run_len, MB);
        runs++;
        run_on = 0;
      end
    end
    chk("fair_runs", runs >= 10, 1'b1);

    // Credit exhaustion: exactly DEPTH transfers without returns.
    do_reset();
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      cyc(0, 1, 4'hF, $urandom, 0);
      if (obs_rdy != 0) cnt++;
    end
    chk("exh_xfers", cnt, DEPTH);
    chk("exh_credits", credits, 8'd0);
    chk("exh_ready_low", obs_rdy, 4'h0);
    cyc(0, 1, 4'hF, $urandom, 1);
    chk("exh_one_crd", credits, 8'd1);
    cnt = (obs_rdy != 0) ? 1 : 0;
    for (int c = 0; c < 10; c++) begin
      cyc(0, 1, 4'hF, $urandom, 0);
      if (obs_rdy != 0) cnt++;
    end
    chk("exh_one_more", cnt, 1);
    chk("exh_credits2", credits, 8'd0);

    // Transfer and return in the same cycle at credits=5.
    for (int c = 0; c < 5; c++) cyc(0, 1, 4'h0, 32'h0, 1);
    chk("sim_pre_credits", credits, 8'd5);
    cyc(0, 1, 4'h2, 32'h0000_3C00, 0);
    cyc(0, 1, 4'h2, 32'h0000_3C00, 1);
    chk("sim_ready", obs_rdy, 4'h2);
    chk("sim_din_valid", fifo_din_valid, 1'b1);
    chk("sim_din", fifo_din, 8'h3C);
    chk("sim_credits", credits, 8'd5);
    cyc(0, 1, 4'h0, 32'h0, 0);

    // Return while full: dropped and sticky error until reset.
    do_reset();
    cyc(0, 1, 4'h0, 32'h0, 1);
    chk("ovf_credits", credits, 8'd128);
    chk("ovf_err", crd_err, 1'b1);
    for (int c = 0; c < 3; c++) cyc(0, 1, 4'h0, 32'h0, 0);
    chk("ovf_err_sticky", crd_err, 1'b1);
    do_reset();
    chk("ovf_err_cleared", crd_err, 1'b0);

    // Reset during beat 2 of a burst from requester 3.
    cyc(0, 1, 4'h8, 32'h4100_0000, 0);
    cyc(0, 1, 4'h8, 32'h4200_0000, 0);
    chk("mid_beat1_valid", fifo_din_valid, 1'b1);
    chk("mid_beat1_din", fifo_din, 8'h42);
    cyc(1, 1, 4'h8, 32'h4300_0000, 0);
    chk("mid_rst_valid", fifo_din_valid, 1'b0);
    chk("mid_rst_credits", credits, 8'd128);
    chk("mid_rst_gnt", gnt_id, 2'd0);
    cyc(0, 1, 4'hF, 32'h4477_6699, 0);
    cyc(0, 1, 4'hF, 32'h4477_6699, 0);
    chk("mid_first_ready", obs_rdy, 4'h1);
    chk("mid_first_din", fifo_din, 8'h99);

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
          4'($urandom), $urandom, ($urandom_range(0, 9) < 6));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ehgu_fifo_wr_arb.md
# ehgu_fifo_wr_arb

Write-side arbiter and credit manager for the ehgu dual-clock FIFO. Shares the FIFO write port among NREQ requesters with round-robin, burst-limited grants. Tracks free FIFO slots with a credit counter, because the FIFO has no full indication. Sits in the write-clock domain, directly in front of the FIFO's en/din_valid/din inputs; credit returns come from the read side, already synchronized into clk0.

## Interface
- NREQ, 4: number of requesters (≥2)
- WIDTH, 8: data width; must match the FIFO's WIDTH
- DEPTH, 128: FIFO depth; initial and maximum credit count
- MAX_BURST, 4: maximum beats per grant (≥1)
- CW (local), $clog2(DEPTH+1): credit counter width
- clk0  in  1  write-domain clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- arb_en  in  1  global enable; low blocks grants and transfers
- req_valid  in  NREQ  per-requester data valid
- req_data  in  NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot-or-zero accept, combinational
- crd_ret  in  1  one credit returned (one FIFO read completed), pulse per slot
- fifo_en  out  1  to FIFO en; registered copy of arb_en
- fifo_din_valid  out  1  to FIFO din_valid; registered
- fifo_din  out  WIDTH  to FIFO din; registered
- gnt_id  out  $clog2(NREQ)  index of current/last granted requester
- credits  out  CW  current free-slot count
- crd_err  out  1  sticky: credit return received while credits==DEPTH

## Operation
- States (package enum): IDLE, GRANT.
- IDLE: if arb_en && credits!=0 && |req_valid, pick the first valid requester at or after rr_ptr (wrapping modulo NREQ). Load gnt_id and clear beat_cnt, then go to GRANT. No req_ready is asserted in IDLE.
- GRANT: req_ready[gnt_id] = arb_en && credits!=0; all other bits are 0. A transfer (xfer) occurs when req_valid[gnt_id] && req_ready[gnt_id]. Each xfer increments beat_cnt.
- Leave GRANT for IDLE at the end of a cycle when any of these holds:
  - xfer happens and beat_cnt+1==MAX_BURST;
  - req_valid[gnt_id] is low;
  - arb_en is low;
  - the credits value after this cycle's update is 0.
- On leaving GRANT, rr_ptr = (gnt_id+1) mod NREQ, so the released requester has lowest priority next time.
- Credits: next = credits − xfer + (crd_ret && credits_eff<DEPTH). With xfer and crd_ret in the same cycle, the count is unchanged.
- Credit overflow: a crd_ret arriving while credits==DEPTH and no xfer is dropped and sets crd_err. crd_err is cleared only by rst.
- Credits never underflow, because ready is gated by credits!=0.

## Timing
- Reset values:
  - credits=DEPTH, state=IDLE, rr_ptr=0, gnt_id=0;
  - fifo_en=0, fifo_din_valid=0, fifo_din=0;
  - crd_err=0, req_ready=0.
- Grant latency: requests seen in IDLE at cycle N give req_ready high in cycle N+1.
- Every grant is followed by at least one IDLE cycle; peak throughput is MAX_BURST/(MAX_BURST+1).
- Data latency: xfer in cycle N gives fifo_din_valid=1 and fifo_din=data in cycle N+1.
- fifo_din holds its value when no xfer occurs; fifo_din_valid drops to 0.
- credits and crd_err are registered and update the cycle after the triggering event.
- rst asserted mid-burst: any xfer in that cycle is discarded, with no output and no credit consumed. All state returns to reset values next cycle.

## Structure
- Package ehgu_fifo_arb_pkg holds:
  - the arb_state_t enum (IDLE, GRANT);
  - a function computing the credit width from DEPTH.
- Sub-module ehgu_rr_pick: combinational rotating priority encoder.
  - Inputs: req vector and rr_ptr.
  - Outputs: winner index and any-valid flag.
  - Parameter: NREQ.
- Top level holds the FSM, beat counter, credit counter and output registers.

## Test plan
- Single requester: NREQ=4, req 2 holds valid for 10 beats, MAX_BURST=4, no crd_ret. Expect bursts of 4, 4 and 2 with one IDLE gap between them; fifo_din follows the data one cycle late; credits end at 118.
- Fairness: all four requesters valid continuously. Expect grant order 0,1,2,3,0… with 4 beats each; gnt_id is never repeated consecutively.
- Credit exhaustion: DEPTH=8, continuous requests, no crd_ret. Expect exactly 8 transfers, then req_ready stays 0 and credits=0. One crd_ret pulse then allows exactly one more transfer.
- Simultaneous xfer and crd_ret at credits=5: credits stays 5.
- crd_ret at credits==DEPTH with no xfer: credits stays DEPTH and crd_err=1 until rst.
- rst pulsed during beat 2 of a burst:
  - no fifo_din_valid for that beat;
  - credits=DEPTH and rr_ptr=0 after reset;
  - requester 0 wins first if valid.
